// File: rtl/ram_be_clr.sv
// ram_be_clr: simple dual-port synchronous RAM with per-byte write enables,
// 1- or 2-cycle read pipeline, selectable read-during-write behaviour and a
// built-in clear engine that zero-fills the array after reset or on request.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   clr             single-cycle request to zero-fill the array
//   wrEn/wrAddr/wrData/wrBe   write strobe, address, data, byte-lane enables
//   rdEn/rdAddr     read strobe and address
//   rdData/rdValid  read data (held between reads) and one-cycle valid pulse
//   ready           high when user accesses are accepted (not clearing)
module ram_be_clr #(
  parameter int unsigned Width        = 32,
  parameter int unsigned Depth        = 16,
  parameter int unsigned ByteW        = 8,
  parameter int unsigned RdLatency    = 1,
  parameter int unsigned RdMode       = 0,
  parameter int unsigned ClearOnReset = 1,
  localparam int unsigned NB = Width / ByteW,
  localparam int unsigned AW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wrEn,
  input  logic [AW-1:0]    wrAddr,
  input  logic [Width-1:0] wrData,
  input  logic [NB-1:0]    wrBe,
  input  logic             rdEn,
  input  logic [AW-1:0]    rdAddr,
  output logic [Width-1:0] rdData,
  output logic             rdValid,
  output logic             ready
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam logic [AW:0]   DepthW   = (AW+1)'(Depth);
  localparam logic [AW-1:0] LastAddr = AW'(Depth - 1);
  localparam state_e        RstState = (ClearOnReset != 0) ? ST_CLEAR : ST_READY;

  state_e            state_q, state_d;
  logic [AW-1:0]     clr_addr_q, clr_addr_d;
  logic              ready_q, ready_d;
  logic              s1_valid_q, s1_valid_d;
  logic [Width-1:0]  s1_data_q, s1_data_d;
  logic [Width-1:0]  mem_q [Depth];

  logic              wr_in_range, rd_in_range;
  logic              wr_fire, rd_fire;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [Width-1:0]  mem_wdata;
  logic [NB-1:0]     mem_be;
  logic [Width-1:0]  rd_word;

  // User accesses only take effect in READY; out-of-range writes are dropped.
  always_comb begin
    wr_in_range = ({1'b0, wrAddr} < DepthW);
    rd_in_range = ({1'b0, rdAddr} < DepthW);
    wr_fire     = wrEn && (state_q == ST_READY) && wr_in_range;
    rd_fire     = rdEn && (state_q == ST_READY);
  end

  // Next-state logic; the clear engine owns the write port while clearing.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    mem_we     = 1'b0;
    mem_addr   = wrAddr;
    mem_wdata  = wrData;
    mem_be     = wrBe;
    case (state_q)
      ST_CLEAR: begin
        mem_we     = 1'b1;
        mem_addr   = clr_addr_q;
        mem_wdata  = '0;
        mem_be     = '1;
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == LastAddr) begin
          state_d    = ST_READY;
          clr_addr_d = '0;
        end
      end
      ST_READY: begin
        mem_we = wr_fire;
        if (clr) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      default: state_d = RstState;
    endcase
    ready_d = (state_d == ST_READY);
  end

  // Read word with optional write-first bypass of the lanes being written.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) rd_word = mem_q[rdAddr];
    if ((RdMode != 0) && wr_fire && (wrAddr == rdAddr)) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wrBe[i]) rd_word[i*ByteW +: ByteW] = wrData[i*ByteW +: ByteW];
      end
    end
    s1_valid_d = rd_fire;
    s1_data_d  = rd_fire ? rd_word : s1_data_q;
  end

  // Control and first read stage; rst flushes in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RstState;
      clr_addr_q <= '0;
      ready_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      ready_q    <= ready_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  // Storage array; not reset, only zeroed through the clear engine.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (mem_be[i]) mem_q[mem_addr][i*ByteW +: ByteW] <= mem_wdata[i*ByteW +: ByteW];
      end
    end
  end

  // Optional second read stage.
  if (RdLatency == 2) begin : g_lat2
    logic             out_valid_q, out_valid_d;
    logic [Width-1:0] out_data_q, out_data_d;

    always_comb begin
      out_valid_d = s1_valid_q;
      out_data_d  = s1_valid_q ? s1_data_q : out_data_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end else begin
        out_valid_q <= out_valid_d;
        out_data_q  <= out_data_d;
      end
    end

    assign rdValid = out_valid_q;
    assign rdData  = out_data_q;
  end else begin : g_lat1
    assign rdValid = s1_valid_q;
    assign rdData  = s1_data_q;
  end

  assign ready = ready_q;

endmodule

// File: doc/ram_be_clr.md
# ram_be_clr

Simple dual-port synchronous RAM with per-byte write enables, a configurable read pipeline (1 or 2 cycles), selectable read-during-write collision behaviour and a built-in clear engine that zero-fills the array after reset or on request. It is the parametrised successor of the team's basic one-write/one-read RAM. It is intended as the common storage primitive under FIFOs, register files and lookup tables in the design.

## Interface
- Width, 32: data word width in bits; must be a multiple of ByteW.
- Depth, 16: number of words; any value >= 2, not required to be a power of two.
- ByteW, 8: bits per write-enable lane; NB = Width/ByteW lanes.
- RdLatency, 1: read latency in cycles; legal values are 1 and 2.
- RdMode, 0: 0 = read-first (old data on collision); 1 = write-first (new data on collision).
- ClearOnReset, 1: 1 = zero-fill the array after reset; 0 = array untouched, block ready immediately.

Ports (AW = $clog2(Depth)):
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  single-cycle request to zero-fill the whole array.
- wrEn  in  1  write strobe.
- wrAddr  in  AW  write address.
- wrData  in  Width  write data.
- wrBe  in  NB  byte-lane enables; lane i covers bits [i*ByteW +: ByteW].
- rdEn  in  1  read strobe.
- rdAddr  in  AW  read address.
- rdData  out  Width  read data; holds its last value when rdValid is low.
- rdValid  out  1  one-cycle pulse marking rdData valid.
- ready  out  1  high when user accesses are accepted, i.e. not clearing.

## Operation
- FSM has two states, CLEAR and READY.
- Reset entry: rst forces the state to CLEAR with clrAddr = 0 when ClearOnReset = 1, otherwise to READY.
- CLEAR:
  - Each cycle, write 0 to mem[clrAddr], then increment clrAddr.
  - At clrAddr == Depth-1, that word is written and the state goes to READY. A clear takes exactly Depth cycles.
  - User wrEn and rdEn are ignored; no rdValid is produced.
  - clr is ignored while clearing.
- READY:
  - clr high moves the state to CLEAR with clrAddr = 0. A wrEn or rdEn in the same cycle as clr is still performed.
- Write: with wrEn high in READY, lane i of mem[wrAddr] is updated only where wrBe[i] = 1. A write with wrBe = 0 changes nothing.
- Read: rdEn high in READY samples rdAddr. Data appears on rdData with rdValid high exactly RdLatency cycles later.
  - Back-to-back reads are allowed every cycle, with full throughput.
- Collision (wrEn and rdEn in the same cycle, wrAddr == rdAddr):
  - RdMode 0: returns the pre-write word.
  - RdMode 1: returns the post-write word, i.e. written lanes new and unwritten lanes old.
- Out-of-range addresses (addr >= Depth):
  - Writes are dropped.
  - Reads return 0 with rdValid still asserted.
- A write followed by a read of the same address on the next cycle always returns the new data, in either RdMode.

## Timing
- Values during and after rst: rdData = 0, rdValid = 0, ready = 0 while rst is high. The read pipeline is flushed, so in-flight reads produce no rdValid.
- ready is registered and equals (state == READY):
  - ClearOnReset = 0: ready = 1 on the first cycle after rst drops.
  - ClearOnReset = 1: ready rises Depth cycles after rst drops.
- clr sampled at edge t makes ready = 0 from t+1 and ready = 1 again at t+1+Depth.
- A rst asserted mid-clear restarts the clear from address 0.
- Read issued at edge t gives rdValid = 1 and rdData valid during the cycle after edge t+RdLatency-1. For RdLatency = 1 that is the cycle immediately after t.
- Reads accepted just before a clr still complete and return pre-clear data.
- The array is not reset by rst other than through the clear engine. With ClearOnReset = 0 its contents survive rst.

## Test plan
- Clear after reset: Depth=16, ClearOnReset=1. Release rst → ready low for exactly 16 cycles then high; a read of every address returns 0x00000000.
- Byte-lane write: write 0xAABBCCDD with wrBe=4'b1111 to addr 3, then 0x11223344 with wrBe=4'b0101 → read of addr 3 returns 0xAA22CC44 with rdValid one cycle after rdEn (RdLatency=1) and two cycles after (RdLatency=2).
- Collision: addr 5 holds 0x0; simultaneous write 0x12345678 (wrBe all ones) and read of addr 5 → RdMode 0 returns 0x00000000, RdMode 1 returns 0x12345678. A read the next cycle returns 0x12345678 in both modes.
- Runtime clear: fill all words with 0xFFFFFFFF, pulse clr → ready low for 16 cycles, wrEn during the clear has no effect, every word then reads 0.
- Reset mid-clear and during reads: assert rst at clear cycle 7 → ready low again for a full 16 cycles after release. Assert rst with 2 reads in flight (RdLatency=2) → no rdValid, rdData = 0.
- Depth=12 (non power of two): write to addr 13 is dropped and a read of addr 13 returns 0 with rdValid=1. The clear completes in 12 cycles.
